// File: rtl/systolic_pkg.sv
// Shared constants, lane/vector types and FSM state encoding for the systolic array feeder.
package systolic_pkg;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int CNT_W = $clog2(N);

  typedef logic [W-1:0] lane_t;
  typedef lane_t [N-1:0] vec_t;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, FLUSH, DONE} skewer_state_e;
endpackage

// File: rtl/systolic_input_skewer_skew_delay_line.sv
// Enabled shift register of DEPTH stages; one per activation lane to build the diagonal skew.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];
endmodule

// File: rtl/systolic_input_skewer.sv
// Weight preload and skewed activation feeder for the NxN systolic array.
// Optional stall counter port enabled by defining SKEWER_PERF_CNT_EN.
module systolic_input_skewer
  import systolic_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [N*W-1:0] w_data,
  input  logic           act_valid,
  output logic           act_ready,
  input  logic [N*W-1:0] act_data,
  input  logic           act_last,
  output logic [N*W-1:0] arr_a,
  output logic [N*W-1:0] arr_b,
  output logic           arr_switch,
  output logic           arr_en,
  output logic           tile_done,
`ifdef SKEWER_PERF_CNT_EN
  output logic [31:0]    stall_cycles,
`endif
  output logic           busy
);
  // state  | meaning
  // IDLE   | wait for weights or (weights loaded) activations
  // LOAD   | accept N weight vectors onto arr_b
  // STREAM | accept activations into the skew lines
  // FLUSH  | shift N-1 zero vectors to drain the skew
  // DONE   | clear skew tail, pulse tile_done next cycle

  localparam logic [CNT_W-1:0] WCNT_MAX = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] FCNT_MAX = CNT_W'(N-2);

  skewer_state_e    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wcnt, r_fcnt;
  logic             r_weights_loaded;
  vec_t             r_arr_b;
  logic             r_arr_switch, r_arr_en, r_tile_done;

  logic             w_w_acc, w_act_acc, w_shift_en;
  vec_t             w_shift_d, w_arr_a;

  assign w_ready   = (r_state == LOAD);
  assign act_ready = (r_state == STREAM);
  assign busy      = (r_state != IDLE);
  assign w_w_acc   = w_valid && w_ready;
  assign w_act_acc = act_valid && act_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_valid)                            w_state_nxt = LOAD;
        else if (act_valid && r_weights_loaded) w_state_nxt = STREAM;
      end
      LOAD:    if (w_w_acc && r_wcnt == WCNT_MAX) w_state_nxt = STREAM;
      STREAM:  if (w_act_acc && act_last)         w_state_nxt = FLUSH;
      FLUSH:   if (r_fcnt == FCNT_MAX)            w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_wcnt           <= '0;
      r_fcnt           <= '0;
      r_weights_loaded <= 1'b0;
      r_arr_b          <= '0;
      r_arr_switch     <= 1'b0;
      r_arr_en         <= 1'b0;
      r_tile_done      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_arr_switch <= w_w_acc;
      r_arr_en     <= w_w_acc || w_act_acc || (r_state == FLUSH);
      r_tile_done  <= (r_state == DONE);
      if (w_w_acc) begin
        r_arr_b <= w_data;
        r_wcnt  <= (r_wcnt == WCNT_MAX) ? '0 : r_wcnt + 1'b1;
        if (r_wcnt == WCNT_MAX) r_weights_loaded <= 1'b1;
      end
      if (r_state == FLUSH) r_fcnt <= (r_fcnt == FCNT_MAX) ? '0 : r_fcnt + 1'b1;
    end
  end

  // DONE shifts one more zero (with arr_en low) so the last lane's tail is cleared.
  assign w_shift_en = w_act_acc || (r_state == FLUSH) || (r_state == DONE);
  assign w_shift_d  = w_act_acc ? act_data : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i + 1), .W(W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_shift_en),
      .i_d  (w_shift_d[i]),
      .o_q  (w_arr_a[i])
    );
  end

  assign arr_a      = w_arr_a;
  assign arr_b      = r_arr_b;
  assign arr_switch = r_arr_switch;
  assign arr_en     = r_arr_en;
  assign tile_done  = r_tile_done;

`ifdef SKEWER_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)                                           r_stall_cycles <= '0;
    else if (r_state == IDLE && w_state_nxt == STREAM) r_stall_cycles <= '0;
    else if (r_state == STREAM && !act_valid && r_stall_cycles != '1)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_systolic_input_skewer.sv
// Self-checking bench: per-cycle behavioural model plus directed literal checks.
module tb_systolic_input_skewer;
  import systolic_pkg::*;

  localparam int VW = N * W;

  logic          clk, rst;
  logic          w_valid, w_ready, act_valid, act_ready, act_last;
  logic [VW-1:0] w_data, act_data, arr_a, arr_b;
  logic          arr_switch, arr_en, tile_done, busy;
`ifdef SKEWER_PERF_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  systolic_input_skewer dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
    .arr_a(arr_a), .arr_b(arr_b), .arr_switch(arr_switch), .arr_en(arr_en),
    .tile_done(tile_done),
`ifdef SKEWER_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  task automatic check(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: tile phase, preload counts, and a history of every shift.
  // A lane i output is the lane i element of the vector shifted i shifts ago.
  int          m_phase;  // 0 idle, 1 load, 2 stream, 3 flush, 4 done
  bit          m_loaded, m_sw, m_en, m_done;
  int          m_wcnt, m_fcnt;
  vec_t        m_b;
  logic [31:0] m_stall;
  vec_t        m_hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_loaded = 0; m_wcnt = 0; m_fcnt = 0; m_b = '0;
      m_sw = 0; m_en = 0; m_done = 0; m_stall = '0; m_hist.delete();
    end else begin
      m_sw = 0; m_en = 0; m_done = 0;
      case (m_phase)
        0: if (w_valid) begin m_phase = 1; m_wcnt = 0; end
           else if (act_valid && m_loaded) begin m_phase = 2; m_stall = '0; end
        1: if (w_valid) begin
             m_b = w_data; m_sw = 1; m_en = 1; m_wcnt++;
             if (m_wcnt == N) begin m_loaded = 1; m_phase = 2; end
           end
        2: if (act_valid) begin
             m_hist.push_back(act_data); m_en = 1;
             if (act_last) begin m_phase = 3; m_fcnt = 0; end
           end else if (m_stall != 32'hFFFF_FFFF) m_stall++;
        3: begin
             m_hist.push_back('0); m_en = 1; m_fcnt++;
             if (m_fcnt == N - 1) m_phase = 4;
           end
        default: begin m_hist.push_back('0); m_done = 1; m_phase = 0; end
      endcase
      if (m_hist.size() > 2 * N) void'(m_hist.pop_front());
    end
  end

  function automatic vec_t exp_a();
    vec_t e = '0;
    vec_t v;
    int sz = m_hist.size();
    for (int i = 0; i < N; i++)
      if (sz > i) begin v = m_hist[sz-1-i]; e[i] = v[i]; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("arr_a", arr_a, exp_a());
      check("arr_b", arr_b, m_b);
      check("arr_switch", VW'(arr_switch), VW'(m_sw));
      check("arr_en", VW'(arr_en), VW'(m_en));
      check("tile_done", VW'(tile_done), VW'(m_done));
      check("busy", VW'(busy), VW'(m_phase != 0));
      check("w_ready", VW'(w_ready), VW'(m_phase == 1));
      check("act_ready", VW'(act_ready), VW'(m_phase == 2));
`ifdef SKEWER_PERF_CNT_EN
      check("stall_cycles", VW'(stall_cycles), VW'(m_stall));
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mkvec(input int k);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(16 * k + i);
    return v;
  endfunction

  // Expected arr_a on the j-th enabled cycle of a 4-vector tile (data then flush).
  function automatic vec_t trace_exp(input int j);
    vec_t v = '0;
    for (int i = 0; i < N; i++)
      if (j - i >= 0 && j - i < N) v[i] = W'(16 * (j - i + 1) + i);
    return v;
  endfunction

  task automatic load_weights(input bit directed);
    logic [VW-1:0] exp;
    w_valid = 1; w_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    act_valid = 0;
    check("enter_load", VW'(w_ready), VW'(1));
    for (int k = 1; k <= N; k++) begin
      w_data = directed ? VW'(k) : {$urandom, $urandom, $urandom, $urandom};
      exp = w_data;
      tick();
      if (directed) begin
        check("load_arr_b", arr_b, exp);
        check("load_switch", VW'(arr_switch), VW'(1));
      end
    end
    w_valid = 0;
    if (directed) check("load_to_stream", VW'(act_ready), VW'(1));
  endtask

  // Streams vectors 1..4 (act_last on 4); gap_before=k inserts 2 bubbles before vector k.
  task automatic run_tile(input int gap_before, input bit lit, output int done_cyc);
    vec_t tr[$];
    vec_t aa;
    int   t = 0, k = 1, gap = 0;
    bit   acc;
    done_cyc = -1;
    while (t < 40 && done_cyc < 0) begin
      if (k <= N && !(k == gap_before && gap < 2)) begin
        act_valid = 1; act_data = mkvec(k); act_last = (k == N);
      end else begin
        if (k == gap_before) gap++;
        act_valid = 0; act_last = 0;
      end
      acc = act_valid && act_ready;
      tick();
      t++;
      if (acc) k++;
      if (arr_en) tr.push_back(arr_a);
      if (tile_done) done_cyc = t;
      aa = arr_a;
      if (lit && t == 1) check("lane0_lat1", VW'(aa[0]), VW'(32'h10));
      if (lit && t == 3) check("lane2_lat3", VW'(aa[2]), VW'(32'h12));
    end
    act_valid = 0; act_last = 0;
    if (done_cyc < 0) check("tile_done_timeout", VW'(0), VW'(1));
    check("flushed_arr_a", arr_a, '0);
    check("trace_len", VW'(tr.size()), VW'(2 * N - 1));
    for (int j = 0; j < tr.size() && j < 2 * N - 1; j++) check("trace", tr[j], trace_exp(j));
  endtask

  int dc;

  initial begin
    clk = 0; rst = 1;
    w_valid = 0; w_data = '0; act_valid = 0; act_data = '0; act_last = 0;
    tick();
    chk_on = 1;
    tick();
    rst = 0;
    check("rst_arr_a", arr_a, '0);
    check("rst_busy", VW'(busy), VW'(0));

    // Activations before weights are ignored
    act_valid = 1; act_data = mkvec(7);
    repeat (3) tick();
    check("no_w_act_ready", VW'(act_ready), VW'(0));
    check("no_w_busy", VW'(busy), VW'(0));
    act_valid = 0;

    load_weights(1);
    run_tile(0, 1, dc);
    check("done_cycle", VW'(dc), VW'(8));
    check("done_idle", VW'(busy), VW'(0));

    // Priority: weights win over activations
    act_valid = 1; act_data = mkvec(9);
    load_weights(0);
    run_tile(0, 0, dc);
    check("done_cycle2", VW'(dc), VW'(8));

    // Reuse retained weights; enter STREAM directly, then 2-cycle stall
    act_valid = 1; act_data = mkvec(1); act_last = 0;
    tick();
    check("reuse_stream", VW'(act_ready), VW'(1));
    check("reuse_no_load", VW'(w_ready), VW'(0));
    run_tile(2, 0, dc);
    check("done_cycle_stall", VW'(dc), VW'(10));
`ifdef SKEWER_PERF_CNT_EN
    check("stall_count", VW'(stall_cycles), VW'(2));
`endif

    // Randomised traffic, checked every cycle by the model
    for (int c = 0; c < 400; c++) begin
      w_valid   = ($urandom_range(0, 15) == 0);
      w_data    = {$urandom, $urandom, $urandom, $urandom};
      act_valid = ($urandom_range(0, 3) != 0);
      act_data  = {$urandom, $urandom, $urandom, $urandom};
      act_last  = ($urandom_range(0, 5) == 0);
      tick();
    end
    w_valid = 0; act_valid = 0; act_last = 0;

    // Reset mid-STREAM after 2 accepts
    rst = 1; tick(); rst = 0;
    load_weights(0);
    act_valid = 1; act_data = mkvec(1); tick();
    act_data = mkvec(2); tick();
    act_valid = 0;
    rst = 1; tick(); rst = 0;
    check("midrst_arr_a", arr_a, '0);
    check("midrst_arr_b", arr_b, '0);
    check("midrst_en", VW'(arr_en), VW'(0));
    check("midrst_done", VW'(tile_done), VW'(0));
    act_valid = 1; act_data = mkvec(3);
    repeat (3) tick();
    check("midrst_no_weights", VW'(act_ready), VW'(0));
    check("midrst_idle", VW'(busy), VW'(0));
    act_valid = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
